// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - register-write command handshake between uart_cmd_rx and its consumer
interface uart_cmd_rx_if;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver and {sync, addr, data, csum} packet parser
module uart_cmd_rx #(
    parameter int         DELAY_FRAMES   = 234,
    parameter int         TIMEOUT_FRAMES = DELAY_FRAMES * 20,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    uart_cmd_rx_if.master cmdIf,
    output logic          frame_err,
    output logic          csum_err,
    output logic          overrun
);
    localparam int CNT_W = $clog2(DELAY_FRAMES);
    localparam int TO_W  = $clog2(TIMEOUT_FRAMES);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} byteState_t;
    typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA, P_CSUM} pktState_t;

    logic             rxMeta;
    logic             rxSync;

    byteState_t       byteState;
    byteState_t       byteStateNext;
    logic [CNT_W-1:0] bitCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             bitEnd;
    logic             stopOk;
    logic             stopBad;
    logic             byteDone;

    pktState_t        pktState;
    pktState_t        pktStateNext;
    logic [7:0]       pktAddr;
    logic [7:0]       pktData;
    logic [TO_W-1:0]  idleCnt;
    logic             timedOut;
    logic             loadCmd;
    logic             csumErrNext;
    logic             overrunNext;

    // Line is asynchronous to clk; idle-high reset value avoids a false start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= uart_rx;
            rxSync <= rxMeta;
        end
    end

    always_comb begin
        byteStateNext = byteState;
        bitEnd        = 1'b0;
        stopOk        = 1'b0;
        stopBad       = 1'b0;
        case (byteState)
            IDLE: begin
                if (!rxSync) begin
                    byteStateNext = START;
                end
            end
            START: begin
                if (bitCnt == HALF_LAST) begin
                    bitEnd        = 1'b1;
                    byteStateNext = rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitCnt == BIT_LAST) begin
                    bitEnd = 1'b1;
                    if (bitIdx == 3'd7) begin
                        byteStateNext = STOP;
                    end
                end
            end
            STOP: begin
                if (bitCnt == BIT_LAST) begin
                    bitEnd = 1'b1;
                    if (rxSync) begin
                        stopOk        = 1'b1;
                        byteStateNext = IDLE;
                    end else begin
                        stopBad       = 1'b1;
                        byteStateNext = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxSync) begin
                    byteStateNext = IDLE;
                end
            end
            default: byteStateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteState <= IDLE;
            bitCnt    <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            byteDone  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byteState <= byteStateNext;
            byteDone  <= stopOk;
            frame_err <= stopBad;
            if (byteState == IDLE || byteState == BRK_WAIT || bitEnd) begin
                bitCnt <= '0;
            end else begin
                bitCnt <= bitCnt + 1'b1;
            end
            if (byteState == IDLE) begin
                bitIdx <= '0;
            end else if (byteState == DATA && bitEnd) begin
                bitIdx   <= bitIdx + 1'b1;
                shiftReg <= {rxSync, shiftReg[7:1]};
            end
        end
    end

    assign timedOut = (pktState != P_SYNC) && (idleCnt == TO_LAST);

    // frame_err and byteDone are mutually exclusive; timeout only acts when neither fires.
    always_comb begin
        pktStateNext = pktState;
        loadCmd      = 1'b0;
        csumErrNext  = 1'b0;
        overrunNext  = 1'b0;
        if (frame_err) begin
            pktStateNext = P_SYNC;
        end else if (byteDone) begin
            case (pktState)
                P_SYNC: begin
                    if (shiftReg == SYNC_BYTE) begin
                        pktStateNext = P_ADDR;
                    end
                end
                P_ADDR: pktStateNext = P_DATA;
                P_DATA: pktStateNext = P_CSUM;
                P_CSUM: begin
                    pktStateNext = P_SYNC;
                    if (shiftReg != (pktAddr ^ pktData)) begin
                        csumErrNext = 1'b1;
                    end else if (cmdIf.cmd_valid && !cmdIf.cmd_ready) begin
                        overrunNext = 1'b1;
                    end else begin
                        loadCmd = 1'b1;
                    end
                end
                default: pktStateNext = P_SYNC;
            endcase
        end else if (timedOut) begin
            pktStateNext = P_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pktState <= P_SYNC;
            pktAddr  <= '0;
            pktData  <= '0;
            idleCnt  <= '0;
            csum_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pktState <= pktStateNext;
            csum_err <= csumErrNext;
            overrun  <= overrunNext;
            if (byteDone && pktState == P_ADDR) begin
                pktAddr <= shiftReg;
            end
            if (byteDone && pktState == P_DATA) begin
                pktData <= shiftReg;
            end
            if (pktState == P_SYNC || byteDone) begin
                idleCnt <= '0;
            end else if (!timedOut) begin
                idleCnt <= idleCnt + 1'b1;
            end
        end
    end

    // A load in the handshake cycle keeps cmd_valid high with the new command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdIf.cmd_valid <= 1'b0;
            cmdIf.cmd_addr  <= '0;
            cmdIf.cmd_data  <= '0;
        end else if (loadCmd) begin
            cmdIf.cmd_valid <= 1'b1;
            cmdIf.cmd_addr  <= pktAddr;
            cmdIf.cmd_data  <= pktData;
        end else if (cmdIf.cmd_valid && cmdIf.cmd_ready) begin
            cmdIf.cmd_valid <= 1'b0;
        end
    end
endmodule
